// File: rtl/tmds_enc_if.sv
// Pixel-side bundle for one TMDS channel encoder: video/control inputs in, 10-bit character out.
interface tmds_enc_if;
  logic       de;
  logic       c0;
  logic       c1;
  logic [7:0] din;
  logic [9:0] dout;

  modport master (output de, output c0, output c1, output din, input dout);
  modport slave  (input de, input c0, input c1, input din, output dout);
endinterface

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder for one DVI/HDMI colour channel, three register stages A/B/C.
// Define TMDS_ENC_OUT_REG_EN to add a fourth register holding dout only.
module tmds_encoder (
  input logic       pixel_clk,
  input logic       rst_n,
  tmds_enc_if.slave bus
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [7:0]        din_a_r;
  logic [3:0]        n1d_a_r;
  logic              de_a_r, c0_a_r, c1_a_r;
  logic [8:0]        qm_s;
  logic [8:0]        qm_b_r;
  logic [3:0]        n1q_b_r, n0q_b_r;
  logic              de_b_r, c0_b_r, c1_b_r;
  logic signed [4:0] diff_s;
  logic signed [4:0] cnt_s;
  logic signed [4:0] cnt_r;
  logic [9:0]        dout_s;
  logic [9:0]        dout_r;

  // Stage A: capture inputs and the popcount of the pixel.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      din_a_r <= 8'd0;
      n1d_a_r <= 4'd0;
      de_a_r  <= 1'b0;
      c0_a_r  <= 1'b0;
      c1_a_r  <= 1'b0;
    end else begin
      din_a_r <= bus.din;
      n1d_a_r <= popcount8(bus.din);
      de_a_r  <= bus.de;
      c0_a_r  <= bus.c0;
      c1_a_r  <= bus.c1;
    end
  end

  // Stage B combinational: transition-minimised 9-bit word.
  always_comb begin
    logic xnor_mode;
    logic acc;
    xnor_mode = (n1d_a_r > 4'd4) || ((n1d_a_r == 4'd4) && !din_a_r[0]);
    acc       = din_a_r[0];
    qm_s      = 9'd0;
    qm_s[0]   = acc;
    for (int i = 1; i < 8; i++) begin
      if (xnor_mode) begin
        acc = ~(acc ^ din_a_r[i]);
      end else begin
        acc = acc ^ din_a_r[i];
      end
      qm_s[i] = acc;
    end
    if (xnor_mode) begin
      qm_s[8] = 1'b0;
    end else begin
      qm_s[8] = 1'b1;
    end
  end

  // Stage B registers: q_m plus its ones/zeros counts.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_b_r  <= 9'd0;
      n1q_b_r <= 4'd0;
      n0q_b_r <= 4'd0;
      de_b_r  <= 1'b0;
      c0_b_r  <= 1'b0;
      c1_b_r  <= 1'b0;
    end else begin
      qm_b_r  <= qm_s;
      n1q_b_r <= popcount8(qm_s[7:0]);
      n0q_b_r <= 4'd8 - popcount8(qm_s[7:0]);
      de_b_r  <= de_a_r;
      c0_b_r  <= c0_a_r;
      c1_b_r  <= c1_a_r;
    end
  end

  // Stage C combinational: DC-balance decision and running disparity update.
  always_comb begin
    diff_s = $signed({1'b0, n1q_b_r}) - $signed({1'b0, n0q_b_r});
    cnt_s  = cnt_r;
    dout_s = 10'd0;
    if (!de_b_r) begin
      cnt_s = 5'sd0;
      case ({c1_b_r, c0_b_r})
        2'b00:   dout_s = 10'h354;
        2'b01:   dout_s = 10'h0AB;
        2'b10:   dout_s = 10'h154;
        2'b11:   dout_s = 10'h2AB;
        default: dout_s = 10'h354;
      endcase
    end else if ((cnt_r == 5'sd0) || (n1q_b_r == n0q_b_r)) begin
      if (qm_b_r[8]) begin
        dout_s = {2'b01, qm_b_r[7:0]};
        cnt_s  = cnt_r + diff_s;
      end else begin
        dout_s = {2'b10, ~qm_b_r[7:0]};
        cnt_s  = cnt_r - diff_s;
      end
    end else if (((cnt_r > 5'sd0) && (n1q_b_r > n0q_b_r)) ||
                 ((cnt_r < 5'sd0) && (n0q_b_r > n1q_b_r))) begin
      dout_s = {1'b1, qm_b_r[8], ~qm_b_r[7:0]};
      cnt_s  = cnt_r + $signed({3'b000, qm_b_r[8], 1'b0}) - diff_s;
    end else begin
      dout_s = {1'b0, qm_b_r[8], qm_b_r[7:0]};
      cnt_s  = cnt_r - $signed({3'b000, ~qm_b_r[8], 1'b0}) + diff_s;
    end
  end

  // Stage C registers: output character and disparity.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= 10'd0;
      cnt_r  <= 5'sd0;
    end else begin
      dout_r <= dout_s;
      cnt_r  <= cnt_s;
    end
  end

`ifdef TMDS_ENC_OUT_REG_EN
  logic [9:0] dout_x_r;

  // Extra output retiming stage toward a distant serializer.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_x_r <= 10'd0;
    end else begin
      dout_x_r <= dout_r;
    end
  end

  assign bus.dout = dout_x_r;
`else
  assign bus.dout = dout_r;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: behavioural TMDS model, directed literals, random stream.
module tb_tmds_encoder;

`ifdef TMDS_ENC_OUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int NMAX = 12000;

  typedef struct {
    bit         de;
    bit         c1;
    bit         c0;
    logic [7:0] d;
    int         idx;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  tmds_enc_if bus();

  tmds_encoder dut (.pixel_clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         ncyc = 0;
  int         m_cnt = 0;
  int         max_abs_cnt = 0;
  logic [9:0] exp_dout = 10'd0;
  logic [9:0] obs [NMAX];
  int         cnt_of [NMAX];
  rec_t       recq [$];
  logic [9:0] outq [$];
  logic [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference encoder: q_m bit i is the parity of d[0..i], inverted on odd i in XNOR mode.
  function automatic logic [9:0] enc_ref(input bit de, input bit c1, input bit c0, input logic [7:0] d);
    int         ones, n1, n0, bal;
    bit         use_xnor, p;
    logic [8:0] qm;
    logic [9:0] o;
    if (!de) begin
      m_cnt = 0;
      return ctrl_tab[{c1, c0}];
    end
    ones = $countones(d);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = p ^ d[i];
      qm[i] = p ^ (use_xnor && (i % 2 == 1));
    end
    qm[8] = !use_xnor;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    bal = n1 - n0;
    if (m_cnt == 0 || n1 == n0) begin
      o = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
      m_cnt = m_cnt + (qm[8] ? bal : -bal);
    end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      m_cnt = m_cnt + 2 * int'(qm[8]) - bal;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      m_cnt = m_cnt + bal - 2 * (1 - int'(qm[8]));
    end
    if (m_cnt > max_abs_cnt) max_abs_cnt = m_cnt;
    if (-m_cnt > max_abs_cnt) max_abs_cnt = -m_cnt;
    return o;
  endfunction

  task automatic model_reset();
    rec_t z;
    z.de = 1'b0; z.c1 = 1'b0; z.c0 = 1'b0; z.d = 8'd0; z.idx = -1;
    recq.delete();
    outq.delete();
    for (int i = 0; i < 2; i++) recq.push_back(z);
    for (int i = 0; i < LAT - 3; i++) outq.push_back(10'd0);
    m_cnt = 0;
  endtask

  // Drive one input at a falling edge, advance the model, compare after the next rising edge.
  task automatic cycle(input bit de, input bit c1, input bit c0, input logic [7:0] d);
    rec_t r, n;
    logic [9:0] e;
    bus.de = de; bus.c1 = c1; bus.c0 = c0; bus.din = d;
    n.de = de; n.c1 = c1; n.c0 = c0; n.d = d; n.idx = ncyc;
    r = recq.pop_front();
    recq.push_back(n);
    e = enc_ref(r.de, r.c1, r.c0, r.d);
    if (r.idx >= 0) cnt_of[r.idx] = m_cnt;
    if (LAT > 3) begin
      exp_dout = outq.pop_front();
      outq.push_back(e);
    end else begin
      exp_dout = e;
    end
    @(posedge clk);
    @(negedge clk);
    obs[ncyc] = bus.dout;
    check("dout_vs_model", bus.dout, exp_dout);
    ncyc++;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int k;
    bus.de = 1'b0; bus.c0 = 1'b0; bus.c1 = 1'b0; bus.din = 8'h00;
    #2 rst_n = 1'b0;
    #1 check("reset_dout", bus.dout, 10'h000);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", bus.dout, 10'h000);
    rst_n = 1'b1;
    model_reset();

    k = ncyc;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("first_edge", obs[k], (LAT == 3) ? 10'h354 : 10'h000);

    // Control words.
    k = ncyc;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    flush();
    check("ctrl_00", obs[k + LAT - 1], 10'h354);
    check("ctrl_01", obs[k + LAT], 10'h0AB);
    check("ctrl_10", obs[k + LAT + 1], 10'h154);
    check("ctrl_11", obs[k + LAT + 2], 10'h2AB);

    // Disparity with din = 0x00.
    k = ncyc;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    flush();
    check("d00_0", obs[k + LAT - 1], 10'h100);
    check("d00_1", obs[k + LAT], 10'h3FF);
    check("d00_2", obs[k + LAT + 1], 10'h100);
    check_int("d00_cnt0", cnt_of[k], -8);
    check_int("d00_cnt1", cnt_of[k + 1], 2);
    check_int("d00_cnt2", cnt_of[k + 2], -6);

    // Disparity with din = 0xFF.
    k = ncyc;
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 8'hFF);
    flush();
    check("dff_0", obs[k + LAT - 1], 10'h200);
    check("dff_1", obs[k + LAT], 10'h0FF);
    check_int("dff_cnt0", cnt_of[k], -8);
    check_int("dff_cnt1", cnt_of[k + 1], -2);

    // Single control cycle clears the disparity.
    k = ncyc;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    flush();
    check("gap_0", obs[k + LAT - 1], 10'h100);
    check("gap_1", obs[k + LAT], 10'h354);
    check("gap_2", obs[k + LAT + 1], 10'h100);

    // Reset mid-line, away from any clock edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    #2 rst_n = 1'b0;
    #1 check("midline_reset", bus.dout, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    k = ncyc;
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("post_reset_edge1", obs[k], (LAT == 3) ? 10'h354 : 10'h000);
    check("post_reset_edge2", obs[k + 1], 10'h354);

    // Random stream: mostly data runs with occasional control gaps.
    max_abs_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 8'($urandom));
    end
    flush();
    tests++;
    if (max_abs_cnt > 10) begin
      fails++;
      $display("FAIL cnt_bound: got %0d, expected at most 10", max_abs_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
